// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the clearable register file.
package regfile_pkg;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;
endpackage

// File: rtl/regfile_clr_dff.sv
// One register-file entry: async-reset flop with clear-over-write hold mux.
module regfile_clr_dff #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         we_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q_q <= '0;
    else if (clr_i) q_q <= '0;
    else if (we_i)  q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks cnt over every entry, one per cycle, strobing its clear.
module regfile_clr_seq import regfile_pkg::*; #(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_req,
  output logic                busy,
  output logic [NUM_REGS-1:0] clr_stb
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // clr_req is only looked at in IDLE, so a request mid-clear cannot restart it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == CLEAR);

  always_comb begin
    clr_stb = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (busy && cnt_q == ADDR_W'(i)) clr_stb[i] = 1'b1;
  end
endmodule

// File: rtl/regfile_clr.sv
// Parametrised GPR/CSR register file: 1 write, 2 comb reads, clear sequencer, sticky err.
// Define REGFILE_CLR_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_clr import regfile_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr0,
  output logic [DATA_W-1:0] rd_data0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic              clr_req,
  output logic              busy,
  output logic              err,
  input  logic              err_clr
);
  localparam logic [ADDR_W:0] N_ENT = (ADDR_W+1)'(NUM_REGS);

  logic [NUM_REGS-1:0]             clr_stb;
  logic [NUM_REGS-1:0][DATA_W-1:0] mem;
  logic                            wr_in_rng, wr_ok, err_set;
  logic                            err_q, err_d;

  regfile_clr_seq #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_stb (clr_stb)
  );

  // NUM_REGS need not be a power of two, so the top address codes can be holes
  assign wr_in_rng = ({1'b0, wr_addr} < N_ENT);
  assign wr_ok     = wr_en & ~busy & wr_in_rng;
  assign err_set   = wr_en & (busy | ~wr_in_rng);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_ent
    regfile_clr_dff #(.W(DATA_W)) u_ent (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (clr_stb[g]),
      .we_i  (wr_ok && wr_addr == ADDR_W'(g)),
      .d_i   (wr_data),
      .q_o   (mem[g])
    );
  end

  // Unmatched (out-of-range) addresses fall through to zero
  always_comb begin
    rd_data0 = '0;
    rd_data1 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr0 == ADDR_W'(i)) rd_data0 = mem[i];
      if (rd_addr1 == ADDR_W'(i)) rd_data1 = mem[i];
    end
`ifdef REGFILE_CLR_BYPASS_EN
    if (wr_ok && rd_addr0 == wr_addr) rd_data0 = wr_data;
    if (wr_ok && rd_addr1 == wr_addr) rd_data1 = wr_data;
`endif
  end

  // A fresh error event outranks err_clr in the same cycle
  assign err_d = err_set | (err_q & ~err_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
endmodule
